// File: rtl/matrix_seq_ctrl_if.sv
// matrix_seq_ctrl_if: pulse inputs, switch data and registered strobes of matrix_seq_ctrl.
// The controller uses the slave modport; whoever drives Start/Ack/Load/CEN/Sw uses master.
interface matrix_seq_ctrl_if #(parameter int IDX_W = 3);
  logic             Start;
  logic             Ack;
  logic             Load;
  logic             CEN;
  logic [7:0]       Sw;
  logic             wr_en;
  logic [IDX_W-1:0] wr_row;
  logic [IDX_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [IDX_W-1:0] rd_i;
  logic [IDX_W-1:0] rd_j;
  logic [IDX_W-1:0] rd_k;
  logic             mac_en;
  logic             mac_first;
  logic             res_we;
  logic             q_I;
  logic             q_Load;
  logic             q_Comp;
  logic             q_Done;

  modport master (
    output Start, Ack, Load, CEN, Sw,
    input  wr_en, wr_row, wr_col, wr_data, rd_i, rd_j, rd_k,
           mac_en, mac_first, res_we, q_I, q_Load, q_Comp, q_Done
  );

  modport slave (
    input  Start, Ack, Load, CEN, Sw,
    output wr_en, wr_row, wr_col, wr_data, rd_i, rd_j, rd_k,
           mac_en, mac_first, res_we, q_I, q_Load, q_Comp, q_Done
  );
endinterface

// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: loads an N x N operand matrix from switches, then sequences N^3 MAC steps.
// Optional macro SINGLE_STEP_EN makes every COMP step wait for a CEN pulse.
module matrix_seq_ctrl #(
  parameter int IDX_W = 3
) (
  input logic              board_clk,
  input logic              Reset,
  matrix_seq_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  // One-hot encoding doubles as the registered q_* flags.
  typedef enum logic [3:0] {
    INIT = 4'b0001,
    LOAD = 4'b0010,
    COMP = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] row, col, row_next, col_next;
  logic [IDX_W-1:0] idx_i, idx_j, idx_k, i_next, j_next, k_next;
  logic [IDX_W-1:0] wr_row, wr_col, wr_row_next, wr_col_next;
  logic [7:0]       wr_data, wr_data_next;
  logic             wr_en, wr_en_next;
  logic             mac_en, mac_en_next;
  logic             mac_first, mac_first_next;
  logic             res_we, res_we_next;
  logic             last_write, last_step;

  assign last_write = wr_en && (wr_row == IDX_MAX) && (wr_col == IDX_MAX);
  assign last_step  = (idx_i == IDX_MAX) && (idx_j == IDX_MAX) && (idx_k == IDX_MAX);

`ifndef SINGLE_STEP_EN
  logic unused_cen;
  assign unused_cen = bus.CEN;
`endif

  always_comb begin
    state_next     = state;
    row_next       = row;
    col_next       = col;
    i_next         = idx_i;
    j_next         = idx_j;
    k_next         = idx_k;
    wr_en_next     = 1'b0;
    wr_row_next    = wr_row;
    wr_col_next    = wr_col;
    wr_data_next   = wr_data;
    mac_en_next    = 1'b0;
    mac_first_next = 1'b0;
    res_we_next    = 1'b0;

    unique case (state)
      INIT: begin
        if (bus.Start) begin
          state_next = LOAD;
          row_next   = '0;
          col_next   = '0;
        end
      end

      LOAD: begin
        // The last write is seen on its strobe cycle, so COMP follows one cycle later.
        if (last_write) begin
          state_next = COMP;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
`ifndef SINGLE_STEP_EN
          mac_en_next    = 1'b1;
          mac_first_next = 1'b1;
`endif
        end else if (bus.Load) begin
          wr_en_next   = 1'b1;
          wr_row_next  = row;
          wr_col_next  = col;
          wr_data_next = bus.Sw;
          col_next     = col + IDX_ONE;
          if (col == IDX_MAX) row_next = row + IDX_ONE;
        end
      end

      COMP: begin
`ifdef SINGLE_STEP_EN
        // A CEN pulse raises mac_en for one cycle; indices advance as it drops.
        if (mac_en) begin
          if (last_step) begin
            state_next = DONE;
          end else begin
            k_next = idx_k + IDX_ONE;
            if (idx_k == IDX_MAX) begin
              j_next = idx_j + IDX_ONE;
              if (idx_j == IDX_MAX) i_next = idx_i + IDX_ONE;
            end
          end
        end else if (bus.CEN) begin
          mac_en_next    = 1'b1;
          mac_first_next = (idx_k == '0);
          res_we_next    = (idx_k == IDX_MAX);
        end
`else
        if (last_step) begin
          state_next = DONE;
        end else begin
          k_next = idx_k + IDX_ONE;
          if (idx_k == IDX_MAX) begin
            j_next = idx_j + IDX_ONE;
            if (idx_j == IDX_MAX) i_next = idx_i + IDX_ONE;
          end
          mac_en_next    = 1'b1;
          mac_first_next = (k_next == '0);
          res_we_next    = (k_next == IDX_MAX);
        end
`endif
      end

      DONE: begin
        if (bus.Ack) state_next = INIT;
      end

      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state     <= INIT;
      row       <= '0;
      col       <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      idx_k     <= '0;
      wr_en     <= 1'b0;
      wr_row    <= '0;
      wr_col    <= '0;
      wr_data   <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      res_we    <= 1'b0;
    end else begin
      state     <= state_next;
      row       <= row_next;
      col       <= col_next;
      idx_i     <= i_next;
      idx_j     <= j_next;
      idx_k     <= k_next;
      wr_en     <= wr_en_next;
      wr_row    <= wr_row_next;
      wr_col    <= wr_col_next;
      wr_data   <= wr_data_next;
      mac_en    <= mac_en_next;
      mac_first <= mac_first_next;
      res_we    <= res_we_next;
    end
  end

  assign bus.wr_en     = wr_en;
  assign bus.wr_row    = wr_row;
  assign bus.wr_col    = wr_col;
  assign bus.wr_data   = wr_data;
  assign bus.rd_i      = idx_i;
  assign bus.rd_j      = idx_j;
  assign bus.rd_k      = idx_k;
  assign bus.mac_en    = mac_en;
  assign bus.mac_first = mac_first;
  assign bus.res_we    = res_we;
  assign bus.q_I       = state[0];
  assign bus.q_Load    = state[1];
  assign bus.q_Comp    = state[2];
  assign bus.q_Done    = state[3];

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// tb_matrix_seq_ctrl: directed run of matrix_seq_ctrl with randomized data, gaps and stray pulses,
// checked against entry/step arithmetic (entry n -> (n/N, n%N), step s -> (s/N^2, (s/N)%N, s%N)).
module tb_matrix_seq_ctrl;
  localparam int IDX_W = 3;
  localparam int N     = 1 << IDX_W;
  localparam logic [3:0] ST_INIT = 4'b0001;
  localparam logic [3:0] ST_LOAD = 4'b0010;
  localparam logic [3:0] ST_COMP = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  logic board_clk = 1'b0;
  logic Reset     = 1'b0;
  int   total     = 0;
  int   bad       = 0;
  int   load_n    = 0;

  matrix_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();

  matrix_seq_ctrl #(.IDX_W(IDX_W)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 board_clk = ~board_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] expected);
    checkOutput(tag, {28'd0, bus.q_Done, bus.q_Comp, bus.q_Load, bus.q_I}, {28'd0, expected});
  endtask

  task automatic tick();
    @(posedge board_clk);
    @(negedge board_clk);
  endtask

  // Hold the pulse inputs for exactly one rising edge, then drop them.
  task automatic applyStimulus(input bit start, input bit ack, input bit load, input bit cen,
                               input logic [7:0] sw);
    bus.Start = start;
    bus.Ack   = ack;
    bus.Load  = load;
    bus.CEN   = cen;
    bus.Sw    = sw;
    tick();
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    bus.Load  = 1'b0;
    bus.CEN   = 1'b0;
  endtask

  task automatic load_entries(input int count, input bit index_data);
    logic [7:0] d;
    int gap;
    for (int n = 0; n < count; n++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'($urandom));
        checkOutput("wr_idle", {31'd0, bus.wr_en}, 32'd0);
        check_state("load_hold", ST_LOAD);
      end
      d = index_data ? 8'(load_n) : 8'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), 1'b1, 1'b0, d);
      checkOutput("wr_en", {31'd0, bus.wr_en}, 32'd1);
      checkOutput("wr_row", {29'd0, bus.wr_row}, load_n / N);
      checkOutput("wr_col", {29'd0, bus.wr_col}, load_n % N);
      checkOutput("wr_data", {24'd0, bus.wr_data}, {24'd0, d});
      load_n++;
    end
  endtask

  task automatic run_compute();
    int steps  = 0;
    int firsts = 0;
    int lasts  = 0;
`ifndef SINGLE_STEP_EN
    int cycles = 0;
    while (bus.q_Comp === 1'b1 && cycles < 2000) begin
      checkOutput("mac_en", {31'd0, bus.mac_en}, 32'd1);
      checkOutput("rd_i", {29'd0, bus.rd_i}, steps / (N * N));
      checkOutput("rd_j", {29'd0, bus.rd_j}, (steps / N) % N);
      checkOutput("rd_k", {29'd0, bus.rd_k}, steps % N);
      checkOutput("mac_first", {31'd0, bus.mac_first}, {31'd0, (steps % N) == 0});
      checkOutput("res_we", {31'd0, bus.res_we}, {31'd0, (steps % N) == N - 1});
      checkOutput("wr_comp", {31'd0, bus.wr_en}, 32'd0);
      if (bus.mac_first === 1'b1) firsts++;
      if (bus.res_we === 1'b1) lasts++;
      steps++;
      cycles++;
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
`else
    int gap;
    for (int s = 0; s < N * N * N; s++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
        checkOutput("mac_idle", {31'd0, bus.mac_en}, 32'd0);
      end
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 8'($urandom));
      checkOutput("mac_en", {31'd0, bus.mac_en}, 32'd1);
      checkOutput("rd_i", {29'd0, bus.rd_i}, s / (N * N));
      checkOutput("rd_j", {29'd0, bus.rd_j}, (s / N) % N);
      checkOutput("rd_k", {29'd0, bus.rd_k}, s % N);
      checkOutput("mac_first", {31'd0, bus.mac_first}, {31'd0, (s % N) == 0});
      checkOutput("res_we", {31'd0, bus.res_we}, {31'd0, (s % N) == N - 1});
      if (bus.mac_first === 1'b1) firsts++;
      if (bus.res_we === 1'b1) lasts++;
      steps++;
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
      checkOutput("mac_one_cycle", {31'd0, bus.mac_en}, 32'd0);
      if (steps == 10) begin
        checkOutput("ss_i", {29'd0, bus.rd_i}, 32'd0);
        checkOutput("ss_j", {29'd0, bus.rd_j}, 32'd1);
        checkOutput("ss_k", {29'd0, bus.rd_k}, 32'd2);
      end
    end
`endif
    checkOutput("step_count", steps, N * N * N);
    checkOutput("first_count", firsts, N * N);
    checkOutput("res_count", lasts, N * N);
    check_state("after_comp", ST_DONE);
    checkOutput("mac_done", {31'd0, bus.mac_en}, 32'd0);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    bus.Load  = 1'b0;
    bus.CEN   = 1'b0;
    bus.Sw    = 8'd0;

    #2 Reset = 1'b1;
    tick();
    check_state("reset_state", ST_INIT);
    checkOutput("reset_wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("reset_mac_en", {31'd0, bus.mac_en}, 32'd0);
    checkOutput("reset_wr_data", {24'd0, bus.wr_data}, 32'd0);
    checkOutput("reset_rd", {23'd0, bus.rd_i, bus.rd_j, bus.rd_k}, 32'd0);
    Reset = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
    check_state("init_ignore", ST_INIT);
    checkOutput("init_no_wr", {31'd0, bus.wr_en}, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    check_state("start_load", ST_LOAD);
    checkOutput("start_load_no_wr", {31'd0, bus.wr_en}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("start_load_no_wr2", {31'd0, bus.wr_en}, 32'd0);

    load_n = 0;
    load_entries(N * N, 1'b1);
    tick();
    check_state("enter_comp", ST_COMP);
    checkOutput("enter_comp_no_wr", {31'd0, bus.wr_en}, 32'd0);
    run_compute();

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    check_state("done_load", ST_DONE);
    checkOutput("done_no_wr", {31'd0, bus.wr_en}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_state("done_start", ST_DONE);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("done_ack", ST_INIT);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_state("run2_start", ST_LOAD);
    load_n = 0;
    load_entries(30, 1'b0);
    Reset = 1'b1;
    #1;
    check_state("reset_mid_load", ST_INIT);
    checkOutput("reset_mid_load_wr", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("reset_mid_load_addr", {26'd0, bus.wr_row, bus.wr_col}, 32'd0);
    checkOutput("reset_mid_load_data", {24'd0, bus.wr_data}, 32'd0);
    tick();
    Reset = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    checkOutput("post_reset_no_wr", {31'd0, bus.wr_en}, 32'd0);
    check_state("post_reset_init", ST_INIT);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    load_n = 0;
    load_entries(N * N, 1'b0);
    tick();
    check_state("run3_comp", ST_COMP);

    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    Reset = 1'b1;
    #1;
    check_state("reset_mid_comp", ST_INIT);
    checkOutput("reset_mid_comp_mac", {31'd0, bus.mac_en}, 32'd0);
    checkOutput("reset_mid_comp_rd", {23'd0, bus.rd_i, bus.rd_j, bus.rd_k}, 32'd0);
    checkOutput("reset_mid_comp_flags", {30'd0, bus.mac_first, bus.res_we}, 32'd0);
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom));
      checkOutput("idle_strobes", {30'd0, bus.mac_en, bus.wr_en}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_seq_ctrl.md
MATRIX_SEQ_CTRL -- requirements
Module: matrix_seq_ctrl

Interface
REQ-001 Parameter: IDX_W, 3, index width; matrix dimension N = 2**IDX_W (8 by default).
REQ-002 board_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  one-cycle pulse; begins a load/compute run.
REQ-005 Ack  input  1  one-cycle pulse; acknowledges a completed run.
REQ-006 Load  input  1  one-cycle pulse; deposits Sw into the current operand entry.
REQ-007 CEN  input  1  one-cycle single-step pulse; used only with the configuration macro defined.
REQ-008 Sw  input  8  switch data for operand entries.
REQ-009 wr_en  output  1  operand-write strobe, one cycle.
REQ-010 wr_row, wr_col  output  IDX_W each  operand-write address.
REQ-011 wr_data  output  8  operand-write data.
REQ-012 rd_i, rd_j, rd_k  output  IDX_W each  compute indices; operands are A[i][k] and A[k][j].
REQ-013 mac_en  output  1  MAC step strobe.
REQ-014 mac_first  output  1  MAC loads the product instead of accumulating.
REQ-015 res_we  output  1  write accumulated result to C[rd_i][rd_j].
REQ-016 q_I, q_Load, q_Comp, q_Done  output  1 each  one-hot state flags.

Function
REQ-017 States SHALL be INIT, LOAD, COMP and DONE, encoded one-hot on the q_* flags, with exactly one flag high at all times.
REQ-018 INIT: Start SHALL move to LOAD and clear the load counters (row, col) to 0; Ack and Load SHALL be ignored.
REQ-019 LOAD: each Load pulse SHALL assert wr_en for exactly one cycle, on the cycle after the pulse, with wr_row/wr_col equal to the current counters and wr_data equal to Sw as sampled on the pulse cycle.
REQ-020 LOAD: after each write, col SHALL increment; when col wraps from N-1 to 0, row SHALL increment.
REQ-021 LOAD: the write to entry (N-1, N-1) SHALL move the machine to COMP, with i, j and k cleared to 0.
REQ-022 LOAD: Start and Ack SHALL be ignored.
REQ-023 COMP: each step SHALL assert mac_en for one cycle with rd_i/rd_j/rd_k equal to the current indices.
REQ-024 COMP: mac_first SHALL equal 1 exactly when k==0, and res_we SHALL equal 1 exactly when k==N-1; both are qualified by mac_en.
REQ-025 COMP index order SHALL be k innermost, then j, then i, each wrapping at N-1 and carrying into the next index.
REQ-026 COMP SHALL run N*N*N steps in total (512 by default).
REQ-027 The step with (i, j, k) = (N-1, N-1, N-1) SHALL move the machine to DONE on the following edge.
REQ-028 COMP: Start, Ack and Load SHALL be ignored.
REQ-029 DONE: Ack SHALL move the machine to INIT.
REQ-030 DONE: Start and Load SHALL be ignored; if Start and Ack arrive in the same cycle, Ack takes effect.
REQ-031 When Start and Load arrive in the same INIT cycle, the machine SHALL enter LOAD and the Load SHALL be discarded, producing no write.
REQ-032 All outputs SHALL be registered.
REQ-033 mac_en, res_we and wr_en SHALL be 0 in every state other than the state that drives them.

Reset
REQ-034 Reset SHALL force INIT (q_I=1, other flags 0) immediately, including in the middle of a LOAD or COMP run.
REQ-035 Reset SHALL clear every counter, index and data output to 0.
REQ-036 After Reset, no write or MAC strobe SHALL be emitted until a new Start is received.

Configuration
REQ-037 Macro SINGLE_STEP_EN: when defined, a COMP step SHALL advance only on a cycle with CEN=1, and mac_en SHALL be high for exactly that one cycle.
REQ-038 Without SINGLE_STEP_EN, COMP SHALL advance every cycle, CEN SHALL be ignored, and COMP SHALL last exactly N*N*N cycles.

Verification
REQ-039 Reset, then Start, then 64 Load pulses with Sw = entry index (0..63) -> 64 wr_en strobes with addresses (0,0) through (7,7) and wr_data 0..63; q_Comp=1 one cycle after the last write.
REQ-040 SINGLE_STEP_EN undefined: after entering COMP -> exactly 512 mac_en cycles, 64 res_we, 64 mac_first; first step is (0,0,0); q_Done after step (7,7,7).
REQ-041 SINGLE_STEP_EN defined: 10 CEN pulses in COMP -> exactly 10 mac_en strobes, and indices end at (0,1,2).
REQ-042 Reset asserted after the 30th Load pulse -> q_I=1, wr_en=0 immediately; the next Start and Load write entry (0,0).
REQ-043 Start+Load in the same INIT cycle -> LOAD entered, no wr_en; Start and Ack pulses during COMP -> no effect.
REQ-044 In DONE, Start and Ack in the same cycle -> INIT on the next edge; Load in DONE -> no wr_en.
